pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating flush-drop counter. It replaces fixed, always-enabled inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so stalls and squashes can propagate without combinational ready paths. Each stage instantiates one copy, and the stage's payload fields are concatenated into `in_data`.

## Interface
- `WIDTH`, 32: payload width in bits; must be ≥1.
- `CNT_WIDTH`, 8: width of the flush-drop counter; must be ≥1.
- `clock` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on `posedge clock`.
- `in_valid` input 1: upstream offers `in_data`.
- `in_ready` output 1: stage can accept; driven only from state (no combinational path from any input).
- `in_data` input WIDTH: upstream payload.
- `out_valid` output 1: `out_data` holds a valid entry.
- `out_ready` input 1: downstream accepts; low = stall.
- `out_data` output WIDTH: payload of the oldest entry.
- `flush` input 1: squash all held entries and any entry offered this cycle.
- `occupancy` output 2: entries held (0, 1 or 2).
- `drop_count` output CNT_WIDTH: valid entries discarded by flush, saturating.

## Operation
- States: EMPTY (0 entries), FULL (main reg valid), SKID (main and skid regs valid).
- Accept: `in_valid & in_ready`. Fire: `out_valid & out_ready`.
- `in_ready` = (state != SKID). `out_valid` = (state != EMPTY). `out_data` = main reg.
- EMPTY: accept → FULL, main ← in_data.
- FULL, accept and fire → FULL, main ← in_data.
- FULL, accept and no fire → SKID, skid ← in_data.
- FULL, fire and no accept → EMPTY.
- FULL, neither → FULL, hold.
- SKID, fire → FULL, main ← skid. Otherwise hold. No accept is possible in SKID.
- Flush has priority over all transitions:
  - next state EMPTY; main and skid regs cleared to 0.
  - An entry accepted in the flush cycle is discarded; the upstream flush is responsible for it.
  - An entry firing in the flush cycle is still delivered downstream; the downstream stage decides from its own flush.
- `drop_count` += (entries held at the flush edge that do not fire that cycle) + (1 if an accept occurs that cycle). Clamps at 2^CNT_WIDTH−1 and never wraps.
- Reset overrides flush and clears `drop_count`.

## Timing
- Reset values: state EMPTY, `out_valid`=0, `out_data`=0, skid reg 0, `in_ready`=1, `occupancy`=0, `drop_count`=0.
- Reset asserted mid-operation discards all entries on that edge. No drop is counted.
- Latency: accept at edge N → `out_valid`=1 after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle when `out_ready` is held high. Occupancy never exceeds 2.
- A one-cycle `out_ready` drop in FULL with a concurrent accept goes to SKID, and `in_ready` deasserts the next cycle. When `out_ready` returns, the first fire goes to FULL and `in_ready` reasserts on the following cycle.
- Order is strictly FIFO; the skid entry is always younger than main.
- `in_valid` without `in_ready`: upstream holds `in_data` stable; the stage ignores it.

## Structure
- Shared package `pipe_pkg`:
  - state typedef `pipe_state_t` (EMPTY=2'b00, FULL=2'b01, SKID=2'b10);
  - `OCC_W`=2.
- One sub-module, `pipe_sat_counter` (parameter `CNT_WIDTH`; inputs `clear`, `inc[1:0]`; output `count`). It is reused by the planned stall/bubble statistics.

## Test plan
- Reset then stream 0x11, 0x22, 0x33 on consecutive cycles with `out_ready`=1 → outputs 0x11/0x22/0x33 one cycle later each; `occupancy` stays 1; `in_ready` stays 1.
- FULL with 0xA1, accept 0xB2 with `out_ready`=0 → SKID, `occupancy`=2, `in_ready`=0 next cycle. Then `out_ready`=1 → 0xA1 then 0xB2 in order, `in_ready` back to 1.
- SKID (0xA1, 0xB2), `flush`=1 with `out_ready`=0 and `in_valid`=1 → EMPTY, `out_data`=0, `drop_count`=2 (nothing was accepted in SKID).
- FULL, `flush`=1 with `out_ready`=1 and an accept of 0xC3 → 0xC3 is dropped, the main entry is delivered, `drop_count` += 1.
- `CNT_WIDTH`=2, force 5 one-entry flushes → `drop_count` saturates at 3.
- Assert `reset` while in SKID with `flush`=1 → all outputs return to reset values and `drop_count`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register and its statistics counters.
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } pipe_state_t;

    localparam int OCC_W = 2;
endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: adds 0..3 per cycle and sticks at all-ones.
module pipe_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [1:0]           inc,
    output logic [CNT_WIDTH-1:0] count
);
    localparam logic [CNT_WIDTH+1:0] MAX = {2'b00, {CNT_WIDTH{1'b1}}};

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH+1:0] sum;

    // Two guard bits so the sum can never wrap before the clamp.
    always_comb begin
        sum     = {2'b00, count_q} + {{CNT_WIDTH{1'b0}}, inc};
        count_d = (sum > MAX) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clock) begin
        if (clear) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer, flush and drop counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 flush,
    output logic [OCC_W-1:0]     occupancy,
    output logic [CNT_WIDTH-1:0] drop_count
);
    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, fire;
    logic [1:0]       drop_inc;

    // in_ready depends only on state, so no combinational ready chain forms.
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_comb begin
        case (state_q)
            FULL:    occupancy = OCC_W'(1);
            SKID:    occupancy = OCC_W'(2);
            default: occupancy = OCC_W'(0);
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = FULL;
                    main_d  = in_data;
                end
                FULL: begin
                    if (accept && fire) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = SKID;
                        skid_d  = in_data;
                    end else if (fire) begin
                        state_d = EMPTY;
                    end
                end
                SKID: if (fire) begin
                    state_d = FULL;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // A firing entry still leaves the stage, so it is not a drop; fire implies occupancy >= 1.
    assign drop_inc = flush ? (occupancy - OCC_W'(fire) + OCC_W'(accept)) : 2'd0;

    pipe_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (drop_inc),
        .count (drop_count)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus, decoupled output monitor.
module tb_pipe_stage_skid;
    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 2;

    logic                 clock = 1'b0;
    logic                 reset, in_valid, in_ready, out_valid, out_ready, flush;
    logic [WIDTH-1:0]     in_data, out_data;
    logic [1:0]           occupancy;
    logic [CNT_WIDTH-1:0] drop_count;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    pipe_stage_skid #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .drop_count (drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every transfer seen downstream must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h expected no transfer", out_data);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_sat[5] = '{1, 2, 3, 3, 3};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_drop", int'(drop_count), 0);
        chk("rst_out_data", int'(out_data), 0);

        // Streaming at full rate
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; exp_q.push_back(8'h11); step();
        chk("stream_occ0", int'(occupancy), 1);
        chk("stream_rdy0", int'(in_ready), 1);
        in_data = 8'h22; exp_q.push_back(8'h22); step();
        chk("stream_occ1", int'(occupancy), 1);
        chk("stream_rdy1", int'(in_ready), 1);
        in_data = 8'h33; exp_q.push_back(8'h33); step();
        chk("stream_occ2", int'(occupancy), 1);
        in_valid = 1'b0; step();
        chk("stream_drain_occ", int'(occupancy), 0);

        // Stall into SKID, then drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 8'hA1; step();
        in_data = 8'hB2; step();
        in_valid = 1'b0;
        chk("skid_occ", int'(occupancy), 2);
        chk("skid_in_ready", int'(in_ready), 0);
        chk("skid_head", int'(out_data), 'hA1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
        out_ready = 1'b1; step();
        chk("unskid_in_ready", int'(in_ready), 1);
        chk("unskid_occ", int'(occupancy), 1);
        step();
        out_ready = 1'b0;
        chk("drained_occ", int'(occupancy), 0);

        // Flush in SKID with an offer that cannot be accepted
        in_valid = 1'b1;
        in_data = 8'hA1; step();
        in_data = 8'hB2; step();
        in_data = 8'h44; flush = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_skid_occ", int'(occupancy), 0);
        chk("flush_skid_valid", int'(out_valid), 0);
        chk("flush_skid_data", int'(out_data), 0);
        chk("flush_skid_rdy", int'(in_ready), 1);
        chk("flush_skid_drop", int'(drop_count), 2);

        // Flush in FULL: main fires and is delivered, concurrent accept is dropped
        in_valid = 1'b1; in_data = 8'h55; step();
        exp_q.push_back(8'h55);
        in_data = 8'hC3; flush = 1'b1; out_ready = 1'b1; step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("flush_full_drop", int'(drop_count), 3);
        chk("flush_full_occ", int'(occupancy), 0);

        // Saturation from zero
        reset = 1'b1; step(); reset = 1'b0;
        chk("sat_start", int'(drop_count), 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = WIDTH'(8'h60 + i); step();
            in_valid = 1'b0; flush = 1'b1; step();
            flush = 1'b0;
            chk($sformatf("sat_drop%0d", i), int'(drop_count), exp_sat[i]);
        end

        // Reset beats flush while in SKID
        in_valid = 1'b1;
        in_data = 8'h77; step();
        in_data = 8'h88; step();
        chk("pre_reset_occ", int'(occupancy), 2);
        reset = 1'b1; flush = 1'b1; in_data = 8'h99; step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_occ", int'(occupancy), 0);
        chk("rst2_out_data", int'(out_data), 0);
        chk("rst2_drop", int'(drop_count), 0);

        step(); step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
